// File: rtl/rare_sram_arb.sv
// rare_sram_arb: round-robin SRAM arbiter with an exclusive stream lock for port 0
module rare_sram_arb #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            stream_enable,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] beb,
  output logic [NUM_PORTS-1:0]            gnt,
  output logic [NUM_PORTS-1:0]            rvalid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rdata,
  output logic                            locked,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic [DATA_WIDTH-1:0]           mem_beb,
  input  logic [DATA_WIDTH-1:0]           mem_rdata
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {ARB, DRAIN, LOCK} state_t;
  state_t          state, nxt;
  logic [IW-1:0]   rr_ptr, gidx;
  logic            any_gnt, rd_gnt, pend;
  logic [RD_LATENCY-1:0] pv;
  logic [IW-1:0]   ptag [RD_LATENCY];
  // Grant selection: round-robin from rr_ptr+1 in ARB, port 0 only in LOCK, nothing in DRAIN or reset
  always_comb begin
    gidx = '0;
    any_gnt = 1'b0;
    if (rst_n && state == ARB && !stream_enable) begin
      any_gnt = |req;
      for (int k = NUM_PORTS; k >= 1; k--)
        if (req[(int'(rr_ptr) + k) % NUM_PORTS]) gidx = IW'((int'(rr_ptr) + k) % NUM_PORTS);
    end else if (rst_n && state == LOCK) begin
      any_gnt = req[0];
    end
    gnt = '0;
    gnt[gidx] = any_gnt;
  end
  // SRAM request mux driven by the granted port; idle bus writes no bits
  always_comb begin
    mem_en    = any_gnt;
    mem_we    = any_gnt & we[gidx];
    mem_addr  = any_gnt ? addr[gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    mem_wdata = any_gnt ? wdata[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
    mem_beb   = any_gnt ? beb[gidx*DATA_WIDTH +: DATA_WIDTH] : '1;
    rd_gnt    = any_gnt & ~we[gidx];
  end
  // Reads still pending after this cycle; the last stage completes in the current cycle
  always_comb begin
    pend = 1'b0;
    for (int k = 0; k < RD_LATENCY - 1; k++) pend = pend | pv[k];
  end
  // Next-state logic: DRAIN waits until the read pipeline will be empty
  always_comb begin
    nxt = state == ARB   ? (stream_enable ? DRAIN : ARB) :
          state == DRAIN ? (!stream_enable ? ARB : (pend ? DRAIN : LOCK)) :
                           (stream_enable ? LOCK : ARB);
  end
  // FSM, round-robin pointer and registered lock flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB;
      rr_ptr <= IW'(NUM_PORTS - 1);
      locked <= 1'b0;
    end else begin
      state  <= nxt;
      locked <= nxt == LOCK;
      if (any_gnt) rr_ptr <= gidx;
    end
  end
  // Read tag pipeline: one stage per cycle of SRAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int k = 0; k < RD_LATENCY; k++) ptag[k] <= '0;
    end else begin
      pv[0]   <= rd_gnt;
      ptag[0] <= gidx;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pv[k]   <= pv[k-1];
        ptag[k] <= ptag[k-1];
      end
    end
  end
  // Return data only to the tagged port; all other slices stay zero
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (pv[RD_LATENCY-1]) begin
      rvalid[ptag[RD_LATENCY-1]] = 1'b1;
      rdata[ptag[RD_LATENCY-1]*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
    end
  end
endmodule

// File: tb/tb_rare_sram_arb.sv
// tb_rare_sram_arb: directed checks of arbitration, read return, drain/lock and reset
module tb_rare_sram_arb;
  logic         clk = 1'b0;
  logic         rst_n, stream_enable;
  logic [3:0]   req, we, gnt, rvalid;
  logic [127:0] addr, wdata, beb, rdata;
  logic         locked, mem_en, mem_we;
  logic [31:0]  mem_addr, mem_wdata, mem_beb, mem_rdata;
  logic [31:0]  mem [64];
  logic [63:0]  wr;
  logic [31:0]  d1, d2;
  int vectors = 0;
  int errs = 0;

  rare_sram_arb #(.NUM_PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .stream_enable(stream_enable), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .beb(beb), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .locked(locked), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_beb(mem_beb), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  function automatic logic [31:0] mv(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // Two-cycle-latency SRAM model with active-low bit-write mask; unwritten words read mv(addr)
  always @(posedge clk) begin
    if (!rst_n) wr <= '0;
    else if (mem_en && mem_we) begin
      mem[mem_addr[5:0]] <= ((wr[mem_addr[5:0]] ? mem[mem_addr[5:0]] : mv(int'(mem_addr[5:0]))) & mem_beb)
                            | (mem_wdata & ~mem_beb);
      wr[mem_addr[5:0]] <= 1'b1;
    end
    d1 <= wr[mem_addr[5:0]] ? mem[mem_addr[5:0]] : mv(int'(mem_addr[5:0]));
    d2 <= d1;
  end
  assign mem_rdata = d2;

  function automatic logic [127:0] at(input int p, input logic [31:0] v);
    return {96'b0, v} << (p * 32);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] eg, input logic [3:0] erv, input logic [127:0] erd);
    chk({tag, " gnt"}, 128'(gnt), 128'(eg));
    chk({tag, " rvalid"}, 128'(rvalid), 128'(erv));
    chk({tag, " rdata"}, rdata, erd);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stream_enable = 1'b0; req = 4'b1111; we = '0;
    addr = '0; wdata = '0; beb = '1;
    nxt(); #1;
    cyc("reset", 4'b0000, 4'b0000, '0);
    chk("reset mem_en", 128'(mem_en), 128'(0));
    chk("reset mem_beb", 128'(mem_beb), 128'(32'hFFFFFFFF));
    chk("reset locked", 128'(locked), 128'(0));
    // alternating reads on ports 0 and 1
    nxt(); rst_n = 1'b1; req = 4'b0011; addr[31:0] = 32'h4; addr[63:32] = 32'h8; #1;
    cyc("A", 4'b0001, 4'b0000, '0);
    chk("A mem_addr", 128'(mem_addr), 128'(32'h4));
    chk("A mem_en", 128'(mem_en), 128'(1));
    nxt(); #1;
    cyc("B", 4'b0010, 4'b0000, '0);
    chk("B mem_addr", 128'(mem_addr), 128'(32'h8));
    nxt(); #1; cyc("C", 4'b0001, 4'b0001, at(0, mv(4)));
    nxt(); #1; cyc("D", 4'b0010, 4'b0010, at(1, mv(8)));
    // masked write on port 1, then read it back
    nxt(); req = 4'b0010; we = 4'b0010; addr[63:32] = 32'h10; wdata[63:32] = 32'hA5A5A5A5; beb[63:32] = 32'hFFFF0000; #1;
    cyc("E", 4'b0010, 4'b0001, at(0, mv(4)));
    chk("E mem_we", 128'(mem_we), 128'(1));
    chk("E mem_beb", 128'(mem_beb), 128'(32'hFFFF0000));
    chk("E mem_wdata", 128'(mem_wdata), 128'(32'hA5A5A5A5));
    nxt(); we = '0; #1;
    cyc("F", 4'b0010, 4'b0010, at(1, mv(8)));
    chk("F mem_we", 128'(mem_we), 128'(0));
    nxt(); req = '0; #1;
    cyc("G", 4'b0000, 4'b0000, '0);
    chk("G idle mem_beb", 128'(mem_beb), 128'(32'hFFFFFFFF));
    chk("G idle mem_addr", 128'(mem_addr), 128'(0));
    chk("G idle mem_en", 128'(mem_en), 128'(0));
    nxt(); #1; cyc("H", 4'b0000, 4'b0010, at(1, 32'hC0DEA5A5));
    // read in flight when stream_enable rises: drain then lock
    nxt(); req = 4'b0010; addr[63:32] = 32'h8; #1; cyc("I", 4'b0010, 4'b0000, '0);
    nxt(); stream_enable = 1'b1; #1;
    cyc("J", 4'b0000, 4'b0000, '0);
    chk("J mem_en", 128'(mem_en), 128'(0));
    chk("J locked", 128'(locked), 128'(0));
    nxt(); #1;
    cyc("K drain", 4'b0000, 4'b0010, at(1, mv(8)));
    chk("K locked", 128'(locked), 128'(0));
    nxt(); #1;
    cyc("L lock", 4'b0000, 4'b0000, '0);
    chk("L locked", 128'(locked), 128'(1));
    // port 0 streams eight reads under lock
    for (int k = 1; k <= 8; k++) begin
      nxt(); req = 4'b0001; addr[31:0] = 32'(k - 1); #1;
      cyc($sformatf("M%0d", k), 4'b0001, k >= 3 ? 4'b0001 : 4'b0000, k >= 3 ? at(0, mv(k - 3)) : '0);
      chk($sformatf("M%0d locked", k), 128'(locked), 128'(1));
    end
    nxt(); req = '0; stream_enable = 1'b0; #1;
    cyc("N1", 4'b0000, 4'b0001, at(0, mv(6)));
    chk("N1 locked", 128'(locked), 128'(1));
    // back in ARB: rotation resumes after port 0, wraps 3 -> 0
    nxt(); req = 4'b1111; addr = {32'h23, 32'h22, 32'h21, 32'h20}; #1;
    cyc("N2", 4'b0010, 4'b0001, at(0, mv(7)));
    chk("N2 locked", 128'(locked), 128'(0));
    nxt(); #1; cyc("N3", 4'b0100, 4'b0000, '0);
    nxt(); #1; cyc("N4", 4'b1000, 4'b0010, at(1, mv(32'h21)));
    nxt(); #1; cyc("N5", 4'b0001, 4'b0100, at(2, mv(32'h22)));
    nxt(); #1; cyc("N6", 4'b0010, 4'b1000, at(3, mv(32'h23)));
    nxt(); req = 4'b0100; #1; cyc("N7 single", 4'b0100, 4'b0001, at(0, mv(32'h20)));
    nxt(); req = 4'b0010; #1; cyc("N8", 4'b0010, 4'b0010, at(1, mv(32'h21)));
    // reset with reads in flight: they are dropped
    nxt(); req = '0; rst_n = 1'b0; #1;
    cyc("N9 rst", 4'b0000, 4'b0000, '0);
    chk("N9 locked", 128'(locked), 128'(0));
    chk("N9 mem_beb", 128'(mem_beb), 128'(32'hFFFFFFFF));
    nxt(); rst_n = 1'b1; #1; cyc("N10", 4'b0000, 4'b0000, '0);
    nxt(); #1; cyc("N11", 4'b0000, 4'b0000, '0);
    nxt(); req = 4'b1111; #1; cyc("N12 first", 4'b0001, 4'b0000, '0);
    nxt(); req = '0; #1; cyc("N13", 4'b0000, 4'b0000, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/rare_sram_arb.md
RARE_SRAM_ARB -- requirements
Module: rare_sram_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requesting ports, 2..8; port 0 is the stream port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data and bit-mask width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-004 SHALL have parameter RD_LATENCY, default 1: SRAM read latency in clk cycles, 1..3.
REQ-005 SHALL have port clk  in  1: single clock for arbiter and SRAM; rising edge.
REQ-006 SHALL have port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port stream_enable  in  1: requests exclusive lock of SRAM for port 0.
REQ-008 SHALL have port req  in  NUM_PORTS: per-port access request.
REQ-009 SHALL have port we  in  NUM_PORTS: per-port write (1) / read (0).
REQ-010 SHALL have port addr  in  NUM_PORTS*ADDR_WIDTH: per-port address, port i at slice i.
REQ-011 SHALL have port wdata  in  NUM_PORTS*DATA_WIDTH: per-port write data.
REQ-012 SHALL have port beb  in  NUM_PORTS*DATA_WIDTH: per-port active-low bit-write mask.
REQ-013 SHALL have port gnt  out  NUM_PORTS: one-hot grant, same cycle as accepted req.
REQ-014 SHALL have port rvalid  out  NUM_PORTS: one-cycle read-data-valid pulse per port.
REQ-015 SHALL have port rdata  out  NUM_PORTS*DATA_WIDTH: per-port read data.
REQ-016 SHALL have port locked  out  1: high while in LOCK state.
REQ-017 SHALL have ports mem_en, mem_we (out 1), mem_addr (out ADDR_WIDTH), mem_wdata, mem_beb (out DATA_WIDTH), mem_rdata (in DATA_WIDTH): SRAM side, same clk.

Function
REQ-018 SHALL implement states ARB, DRAIN, LOCK.
REQ-019 ARB: gnt SHALL go to the highest-priority requesting port, round-robin; priority order starts at rr_ptr+1 mod NUM_PORTS.
REQ-020 rr_ptr SHALL update to the granted index on the clk edge of each grant; unchanged when no grant.
REQ-021 ARB -> DRAIN when stream_enable=1; in the same cycle no grant SHALL issue.
REQ-022 DRAIN: no grants; -> LOCK when no read is in flight (read pipeline empty), possibly the cycle after entry.
REQ-023 LOCK: only port 0 served; gnt[0]=req[0] every cycle; other ports gnt=0; locked=1.
REQ-024 LOCK -> ARB when stream_enable=0; DRAIN -> ARB directly when stream_enable drops before lock (no grant that cycle).
REQ-025 mem_en SHALL equal |gnt; mem_we, mem_addr, mem_wdata, mem_beb SHALL be the granted port's signals, combinational.
REQ-026 With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_beb all-ones (no bits written).
REQ-027 Each granted read SHALL push the port index into a RD_LATENCY-deep tag pipeline; each cycle the pipeline shifts.
REQ-028 Exactly RD_LATENCY cycles after a read grant, rvalid[i]=1 for the tagged port and rdata slice i = mem_rdata.
REQ-029 rdata slice of any port without rvalid SHALL be 0 (no data leaks between ports).
REQ-030 Writes SHALL produce no rvalid; back-to-back grants every cycle SHALL be supported at full throughput.
REQ-031 Simultaneous stream_enable rise and pending reads: in-flight reads SHALL complete and deliver rvalid before LOCK.
REQ-032 Index widths SHALL be clog2(NUM_PORTS); rr_ptr wraps NUM_PORTS-1 -> 0.

Reset
REQ-033 On rst_n=0 (async): state=ARB, rr_ptr=NUM_PORTS-1 (port 0 first), tag pipeline cleared, rvalid=0, rdata=0, gnt=0, locked=0, mem_en=0, mem_beb all-ones.
REQ-034 Reset mid-read SHALL drop the in-flight read; no rvalid after release.
REQ-035 First grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-036 Reset, req=2'b11 held, reads, NUM_PORTS=2 -> gnt alternates 01,10,01,...; rvalid per port RD_LATENCY cycles after each grant.
REQ-037 Port 1 write addr 0x10, wdata 0xA5A5A5A5, beb 0xFFFF0000; then port 1 read 0x10 -> mem_beb=0xFFFF0000 on write; rvalid[1] with rdata[1]=mem_rdata, rdata[0]=0.
REQ-038 RD_LATENCY=2, port 1 read granted, stream_enable rises next cycle -> DRAIN 1 cycle, rvalid[1] delivered, then locked=1; req[1] during LOCK -> gnt[1]=0.
REQ-039 In LOCK, port 0 reads every cycle for 8 cycles -> 8 rvalid[0] pulses; stream_enable=0 -> ARB, next grant follows rr_ptr.
REQ-040 NUM_PORTS=4, req=4'b1111 -> grant order 0,1,2,3,0 (wrap); req=4'b0100 only -> gnt=4'b0100 immediately.
REQ-041 rst_n asserted one cycle after read grant -> all outputs reset values, no rvalid after release.
